rf_access_sequencer: RTL
========================

# rf_access_sequencer

Control sequencer upstream of REGISTER_FILE_32x32: accepts one decoded 32-bit instruction at a time, drives the register file read port to fetch source operands, presents them to the ALU, waits for the result, then drives the register file write port to retire it. Non-pipelined, one instruction in flight; sits between instruction fetch and the register file / ALU pair in the processor datapath.

## Interface
- DATA_WIDTH, 32, operand/result width
- ADDR_WIDTH, 5, register index width
- CLK  input  1  system clock, all state on rising edge
- RST  input  1  reset, asynchronous, active-high
- INSTR  input  32  instruction; opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0]
- INSTR_VALID  input  1  INSTR is valid this cycle
- INSTR_READY  output  1  sequencer can accept an instruction
- RF_ADDR_R1  output  ADDR_WIDTH  register file read address 1 (rs)
- RF_ADDR_R2  output  ADDR_WIDTH  register file read address 2 (rt)
- RF_ADDR_W  output  ADDR_WIDTH  register file write address
- RF_DATA_W  output  DATA_WIDTH  register file write data
- RF_READ  output  1  register file read strobe
- RF_WRITE  output  1  register file write strobe
- RF_DATA_R1  input  DATA_WIDTH  register file read data 1
- RF_DATA_R2  input  DATA_WIDTH  register file read data 2
- OP1, OP2  output  DATA_WIDTH  ALU operands
- OP_VALID  output  1  OP1/OP2 valid, ALU may start
- ALU_RESULT  input  DATA_WIDTH  ALU result
- ALU_DONE  input  1  ALU_RESULT valid this cycle
- RETIRE  output  1  one-cycle pulse when an instruction completes
- INSTR_CNT  output  32  retired-instruction count (see Configuration)

## Operation
- States: IDLE, READ, CAPT, EXEC, WB.
- IDLE: INSTR_READY=1. On INSTR_VALID=1 at rising edge: latch INSTR, go READ. Otherwise stay.
- Decode on latch: opcode==0 -> R-type, dest=rd, OP2 from RF_DATA_R2; opcode!=0 -> I-type, dest=rt, OP2 = sign-extended imm[15:0].
- READ: RF_READ=1, RF_ADDR_R1=rs, RF_ADDR_R2=rt; go CAPT.
- CAPT: RF_READ=1, addresses held; at end of cycle sample RF_DATA_R1 into OP1, RF_DATA_R2 (R-type) or sign-extended imm (I-type) into OP2; go EXEC.
- EXEC: OP_VALID=1; OP1/OP2 stable. On ALU_DONE=1 latch ALU_RESULT into RF_DATA_W, go WB.
- WB: RF_ADDR_W=dest, RF_WRITE=1 unless dest==0 (write to r0 suppressed, RF_WRITE stays 0, cycle still spent); RETIRE=1; go IDLE.
- RF_READ and RF_WRITE never high in the same cycle.
- INSTR_VALID outside IDLE ignored (no queuing); ALU_DONE outside EXEC ignored.
- RST high at any time: immediately IDLE; all outputs to reset values; in-flight instruction discarded, no write issued.

## Timing
- Reset values: INSTR_READY=1 (post-reset IDLE), RF_READ=0, RF_WRITE=0, OP_VALID=0, RETIRE=0, RF_ADDR_*=0, RF_DATA_W=0, OP1=OP2=0, INSTR_CNT=0.
- Accept at edge 0 -> READ cycle 1 -> CAPT cycle 2 -> EXEC from cycle 3.
- ALU_DONE sampled at edge of cycle 3+k -> WB in next cycle -> IDLE next; minimum accept-to-accept spacing 5 cycles (ALU_DONE in first EXEC cycle).
- ALU_DONE already high on entry to EXEC: taken on first EXEC edge.
- Outputs registered; no combinational path from inputs to outputs.

## Configuration
- RF_SEQ_INSTR_CNT_EN defined: INSTR_CNT increments by 1 on every RETIRE (including r0-destination instructions), wraps 0xFFFFFFFF -> 0, cleared by RST.
- Undefined: counter logic not compiled; INSTR_CNT tied to 0.

## Test plan
- Reset: RST=1 mid-EXEC -> same cycle RF_WRITE=0, OP_VALID=0, INSTR_READY=1; after release no write to the discarded dest.
- R-type INSTR=0x00412020 (rs=2, rt=1, rd=4), RF returns 5 and 7, ALU_DONE with 12 in first EXEC cycle -> RF_ADDR_R1=2, RF_ADDR_R2=1, OP1=5, OP2=7, then RF_WRITE=1, RF_ADDR_W=4, RF_DATA_W=12, RETIRE one pulse; 5 cycles total.
- I-type INSTR=0x2043FFFF (rs=2, rt=3, imm=-1), RF_DATA_R1=10 -> OP2=0xFFFFFFFF, RF_ADDR_W=3.
- dest=r0 (INSTR=0x00220020) -> WB cycle with RF_WRITE=0, RETIRE=1, INSTR_CNT+1 when RF_SEQ_INSTR_CNT_EN defined.
- ALU_DONE delayed 4 cycles, INSTR_VALID held high throughout -> OP_VALID high 4 cycles, OP1/OP2 stable, second instruction accepted only after return to IDLE.
- 3 back-to-back instructions with RF_SEQ_INSTR_CNT_EN -> INSTR_CNT=3; without macro -> INSTR_CNT=0.

Source files
------------

// File: rtl/rf_access_sequencer.sv
// rf_access_sequencer
// Non-pipelined control sequencer between instruction fetch and the
// REGISTER_FILE_32x32 / ALU pair. One instruction in flight: latch and decode,
// read rs/rt from the register file, present operands to the ALU, wait for
// ALU_DONE, then write the result back (writes to r0 are suppressed).
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   INSTR/_VALID      decoded instruction in; INSTR_READY high while idle
//   RF_ADDR_R1/R2     read addresses (rs, rt), RF_READ strobe
//   RF_DATA_R1/R2     read data from the register file
//   RF_ADDR_W/DATA_W  write address/data, RF_WRITE strobe
//   OP1/OP2/OP_VALID  ALU operands and start qualifier
//   ALU_RESULT/DONE   ALU result and its valid pulse
//   RETIRE            one-cycle pulse per completed instruction
//   INSTR_CNT         retired-instruction count
//
// Build option
//   RF_SEQ_INSTR_CNT_EN  when defined, INSTR_CNT counts RETIRE pulses
//                        (wrapping); otherwise INSTR_CNT is tied to zero.
module rf_access_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           INSTR,
    input  logic                  INSTR_VALID,
    output logic                  INSTR_READY,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0] RF_DATA_W,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
    output logic [DATA_WIDTH-1:0] OP1,
    output logic [DATA_WIDTH-1:0] OP2,
    output logic                  OP_VALID,
    input  logic [DATA_WIDTH-1:0] ALU_RESULT,
    input  logic                  ALU_DONE,
    output logic                  RETIRE,
    output logic [31:0]           INSTR_CNT
);

    localparam int unsigned CNT_WIDTH = 32;
    localparam int unsigned IMM_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_EXEC,
        S_WB
    } state_t;

    // Decoded fields kept for the lifetime of the instruction
    typedef struct packed {
        logic                  is_r;
        logic [ADDR_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0] imm;
    } decode_t;

    state_t  state_q, state_d;
    decode_t dec_q, dec_d;

    logic                  ready_d, read_d, write_d, opv_d, retire_d;
    logic [ADDR_WIDTH-1:0] addr_r1_d, addr_r2_d, addr_w_d;
    logic [DATA_WIDTH-1:0] data_w_d, op1_d, op2_d;
    logic                  instr_is_r;

    assign instr_is_r = (INSTR[31:26] == 6'd0);

    // Next state and next values of every registered output
    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        ready_d   = INSTR_READY;
        read_d    = RF_READ;
        write_d   = RF_WRITE;
        opv_d     = OP_VALID;
        retire_d  = RETIRE;
        addr_r1_d = RF_ADDR_R1;
        addr_r2_d = RF_ADDR_R2;
        addr_w_d  = RF_ADDR_W;
        data_w_d  = RF_DATA_W;
        op1_d     = OP1;
        op2_d     = OP2;

        case (state_q)
            S_IDLE: begin
                if (INSTR_VALID) begin
                    state_d    = S_READ;
                    dec_d.is_r = instr_is_r;
                    dec_d.dest = instr_is_r ? ADDR_WIDTH'(INSTR[15:11])
                                            : ADDR_WIDTH'(INSTR[20:16]);
                    dec_d.imm  = {{(DATA_WIDTH - IMM_WIDTH){INSTR[15]}}, INSTR[15:0]};
                    addr_r1_d  = ADDR_WIDTH'(INSTR[25:21]);
                    addr_r2_d  = ADDR_WIDTH'(INSTR[20:16]);
                    ready_d    = 1'b0;
                    read_d     = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                // Read data is valid by the end of the second read cycle
                state_d = S_EXEC;
                read_d  = 1'b0;
                opv_d   = 1'b1;
                op1_d   = RF_DATA_R1;
                op2_d   = dec_q.is_r ? RF_DATA_R2 : dec_q.imm;
            end
            S_EXEC: begin
                if (ALU_DONE) begin
                    state_d  = S_WB;
                    opv_d    = 1'b0;
                    data_w_d = ALU_RESULT;
                    addr_w_d = dec_q.dest;
                    write_d  = (dec_q.dest != '0);
                    retire_d = 1'b1;
                end
            end
            S_WB: begin
                state_d  = S_IDLE;
                write_d  = 1'b0;
                retire_d = 1'b0;
                ready_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            dec_q       <= '0;
            INSTR_READY <= 1'b1;
            RF_READ     <= 1'b0;
            RF_WRITE    <= 1'b0;
            OP_VALID    <= 1'b0;
            RETIRE      <= 1'b0;
            RF_ADDR_R1  <= '0;
            RF_ADDR_R2  <= '0;
            RF_ADDR_W   <= '0;
            RF_DATA_W   <= '0;
            OP1         <= '0;
            OP2         <= '0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            INSTR_READY <= ready_d;
            RF_READ     <= read_d;
            RF_WRITE    <= write_d;
            OP_VALID    <= opv_d;
            RETIRE      <= retire_d;
            RF_ADDR_R1  <= addr_r1_d;
            RF_ADDR_R2  <= addr_r2_d;
            RF_ADDR_W   <= addr_w_d;
            RF_DATA_W   <= data_w_d;
            OP1         <= op1_d;
            OP2         <= op2_d;
        end
    end

`ifdef RF_SEQ_INSTR_CNT_EN
    // Retired-instruction counter, advances at the end of each WB cycle
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (RETIRE) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign INSTR_CNT = cnt_q;
`else
    assign INSTR_CNT = '0;
`endif

endmodule
